// File: rtl/delay_spy_sensor.sv
// delay_spy_sensor: measurement front end for the on-chip timing/voltage spy.
// A rising edge is launched into a chain of inverting stages and sampled one
// clock later. The depth the edge reached is decoded, and a run of
// 2^AVG_LOG2 measurements reports the mean, minimum and maximum depth.
module delay_spy_sensor #(
    parameter int CHAIN_LEN    = 64,
    parameter int AVG_LOG2     = 4,
    parameter int SETTLE_CYC   = 8,
    parameter int SIM_STAGE_PS = 250,
    parameter int CNT_W        = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] depth_avg,
    output logic [CNT_W-1:0] depth_min,
    output logic [CNT_W-1:0] depth_max,
    output logic             saturated
);

    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int NMEAS  = 1 << AVG_LOG2;
    localparam int SET_W  = $clog2(SETTLE_CYC);
    localparam int MEAS_W = AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE, SETTLE, LAUNCH, CAPTURE, SYNC, DECODE, FINISH
    } sensorState_t;

    sensorState_t state;
    sensorState_t nextState;

    logic                 launch;
    (* keep = "true" *) logic [CHAIN_LEN-1:0] raw;
    logic [CHAIN_LEN-1:0] capRaw_p1;
    logic [CHAIN_LEN-1:0] capRaw_p2;
    logic [CNT_W-1:0]     depthNow;
    logic [SET_W-1:0]     settleCnt;
    logic [MEAS_W-1:0]    measCnt;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     minDepth;
    logic [CNT_W-1:0]     maxDepth;
    logic                 satAcc;

    // Stage delay only matters to a timed netlist simulation; the RTL chain is zero-delay.
    logic unusedSimStagePs;
    assign unusedSimStagePs = ^SIM_STAGE_PS;

    // Index of the first stage that has not yet taken the launched value.
    // Scanning from the top lets the lowest zero win, so later bubbles are ignored.
    function automatic logic [CNT_W-1:0] firstZero(input logic [CHAIN_LEN-1:0] capRaw);
        logic [CNT_W-1:0] d;
        d = CNT_W'(CHAIN_LEN);
        for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
            if ((capRaw[i] ^ (i % 2 == 0)) == 1'b0) d = CNT_W'(i);
        end
        return d;
    endfunction

    // Mean of a full run: plain truncating shift, no rounding.
    function automatic logic [CNT_W-1:0] truncMean(input logic [ACC_W-1:0] accIn);
        return CNT_W'(accIn >> AVG_LOG2);
    endfunction

    // Inverter chain; each stage is its own kept net so it is not collapsed.
    for (genvar i = 0; i < CHAIN_LEN; i++) begin : gStage
        (* keep = "true" *) logic stageOut;
        if (i == 0) begin : gHead
            assign stageOut = ~launch;
        end else begin : gLink
            assign stageOut = ~gStage[i-1].stageOut;
        end
        assign raw[i] = stageOut;
    end

    assign depthNow = firstZero(capRaw_p2);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state logic for the measurement sequence.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SETTLE;
            SETTLE:  if (settleCnt == SET_W'(SETTLE_CYC - 1)) nextState = LAUNCH;
            LAUNCH:  nextState = CAPTURE;
            CAPTURE: nextState = SYNC;
            SYNC:    nextState = DECODE;
            DECODE:  nextState = (measCnt < MEAS_W'(NMEAS - 1)) ? SETTLE : FINISH;
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Stage p1: sample the chain one clock after launch; stage p2: second flop against metastability.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) capRaw_p1 <= raw;
        if (state == SYNC)    capRaw_p2 <= capRaw_p1;
    end

    // Launch flop, run counters, statistics accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            depth_avg <= '0;
            depth_min <= '0;
            depth_max <= '0;
            saturated <= 1'b0;
            launch    <= 1'b0;
            settleCnt <= '0;
            measCnt   <= '0;
            acc       <= '0;
            minDepth  <= '0;
            maxDepth  <= '0;
            satAcc    <= 1'b0;
        end else begin
            done      <= 1'b0;
            // High from the launch edge until the measurement is decoded.
            launch    <= (nextState == CAPTURE) || (nextState == SYNC) || (nextState == DECODE);
            settleCnt <= (state == SETTLE && nextState == SETTLE) ? settleCnt + SET_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        minDepth <= '1;
                        maxDepth <= '0;
                        satAcc   <= 1'b0;
                        measCnt  <= '0;
                        busy     <= 1'b1;
                    end
                end
                DECODE: begin
                    acc     <= acc + ACC_W'(depthNow);
                    if (depthNow <= minDepth) minDepth <= depthNow;
                    if (depthNow >= maxDepth) maxDepth <= depthNow;
                    satAcc  <= satAcc | (depthNow == CNT_W'(CHAIN_LEN));
                    measCnt <= measCnt + MEAS_W'(1);
                end
                FINISH: begin
                    depth_avg <= truncMean(acc);
                    depth_min <= minDepth;
                    depth_max <= maxDepth;
                    saturated <= satAcc;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_spy_sensor.sv
// Bench for delay_spy_sensor: free-running chain runs plus runs where the
// synchroniser output is overridden with random thermometer codes, checked
// against a run-level statistics model.
`timescale 1ns/1ps
module tb_delay_spy_sensor;

    localparam int CHAIN_LEN  = 64;
    localparam int AVG_LOG2   = 4;
    localparam int SETTLE_CYC = 8;
    localparam int CNT_W      = 7;
    localparam int NMEAS      = 1 << AVG_LOG2;
    localparam int PERIOD     = SETTLE_CYC + 4;
    localparam int LATENCY    = NMEAS * PERIOD + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] depth_avg;
    logic [CNT_W-1:0] depth_min;
    logic [CNT_W-1:0] depth_max;
    logic             saturated;

    int checks;
    int failures;
    int depths[NMEAS];
    int expAvg, expMin, expMax, expSat;
    logic [CHAIN_LEN-1:0] forcePat;

    delay_spy_sensor #(
        .CHAIN_LEN(CHAIN_LEN), .AVG_LOG2(AVG_LOG2), .SETTLE_CYC(SETTLE_CYC), .SIM_STAGE_PS(250)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .depth_avg(depth_avg), .depth_min(depth_min), .depth_max(depth_max),
        .saturated(saturated)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Raw capture word for a given depth: stages below d carry the launched
    // value, stage d does not, stages above are random (bubbles).
    function automatic logic [CHAIN_LEN-1:0] makePattern(input int d);
        logic [CHAIN_LEN-1:0] n;
        logic [CHAIN_LEN-1:0] evenMask;
        n = {$urandom, $urandom};
        for (int i = 0; i < CHAIN_LEN; i++) begin
            evenMask[i] = (i % 2 == 0);
            if (i < d)       n[i] = 1'b1;
            else if (i == d) n[i] = 1'b0;
        end
        return n ^ evenMask;
    endfunction

    task automatic checkHeld(input string tag);
        checkEq({tag, "-avg"}, 32'(depth_avg), expAvg);
        checkEq({tag, "-min"}, 32'(depth_min), expMin);
        checkEq({tag, "-max"}, 32'(depth_max), expMax);
        checkEq({tag, "-sat"}, 32'(saturated), expSat);
    endtask

    // One full run of depths[]; starts and ends at #1 after a rising edge.
    task automatic runMeasure(input string tag, input bit useForce);
        int sum, mn, mx, sat;
        sum = 0; mn = CHAIN_LEN; mx = 0; sat = 0;
        for (int m = 0; m < NMEAS; m++) begin
            sum += depths[m];
            if (depths[m] < mn) mn = depths[m];
            if (depths[m] > mx) mx = depths[m];
            if (depths[m] == CHAIN_LEN) sat = 1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int m = 0; m < NMEAS; m++) begin
            if (useForce) begin
                forcePat = makePattern(depths[m]);
                force dut.capRaw_p2 = forcePat;
            end
            if (m == 0 || m == NMEAS / 2) begin
                checkEq({tag, "-busy"}, 32'(busy), 1);
                checkEq({tag, "-nodone"}, 32'(done), 0);
                checkHeld({tag, "-held"});
            end
            if (m == 3) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (PERIOD - 1) @(posedge clk);
            #1;
        end
        checkEq({tag, "-finishNoDone"}, 32'(done), 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkEq({tag, "-done"}, 32'(done), 1);
        checkEq({tag, "-busyLow"}, 32'(busy), 0);
        expAvg = sum >> AVG_LOG2;
        expMin = mn;
        expMax = mx;
        expSat = sat;
        checkHeld(tag);
        @(posedge clk); #1;
        checkEq({tag, "-donePulse"}, 32'(done), 0);
        checkEq({tag, "-idle"}, 32'(busy), 0);
        if (useForce) release dut.capRaw_p2;
    endtask

    task automatic resetInDecode();
        int doneCnt;
        for (int m = 0; m < NMEAS; m++) depths[m] = 40;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int m = 0; m < 8; m++) begin
            forcePat = makePattern(depths[m]);
            force dut.capRaw_p2 = forcePat;
            repeat (PERIOD - 1) @(posedge clk);
            #1;
            if (m < 7) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        #1;
        expAvg = 0; expMin = 0; expMax = 0; expSat = 0;
        checkEq("rstDecode-busy", 32'(busy), 0);
        checkEq("rstDecode-done", 32'(done), 0);
        checkEq("rstDecode-launch", 32'(dut.launch), 0);
        checkHeld("rstDecode");
        @(posedge clk); #1;
        rst = 1'b0;
        release dut.capRaw_p2;
        doneCnt = 0;
        for (int c = 0; c < LATENCY + 10; c++) begin
            @(posedge clk); #1;
            if (done) doneCnt++;
        end
        checkEq("rstDecode-noDone", 32'(doneCnt), 0);
        checkEq("rstDecode-stayIdle", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        checks = 0; failures = 0;
        expAvg = 0; expMin = 0; expMax = 0; expSat = 0;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEq("reset-busy", 32'(busy), 0);
        checkEq("reset-done", 32'(done), 0);
        checkEq("reset-launch", 32'(dut.launch), 0);
        checkHeld("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-delay chain: the edge always reaches the end.
        for (int m = 0; m < NMEAS; m++) depths[m] = CHAIN_LEN;
        runMeasure("natural", 1'b0);

        for (int m = 0; m < NMEAS; m++) depths[m] = 40;
        runMeasure("const40", 1'b1);

        for (int m = 0; m < NMEAS; m++) depths[m] = (m % 2 == 0) ? 40 : 50;
        runMeasure("alt4050", 1'b1);

        for (int m = 0; m < NMEAS; m++) depths[m] = (m % 2 == 0) ? 4 : 5;
        runMeasure("trunc45", 1'b1);

        for (int r = 0; r < 3; r++) begin
            for (int m = 0; m < NMEAS; m++) depths[m] = int'($urandom_range(0, CHAIN_LEN));
            if (r == 0) begin
                depths[0] = 0;
                depths[5] = CHAIN_LEN;
            end
            runMeasure($sformatf("random%0d", r), 1'b1);
        end

        resetInDecode();

        for (int m = 0; m < NMEAS; m++) depths[m] = int'($urandom_range(1, CHAIN_LEN - 1));
        runMeasure("postReset", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
